// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data responder bridging pipeline load/store requests to an SRAM-like bus.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   rreq, wreq           packed read {valid,addr,size} / write {valid,addr,data,size} requests
//   rd_signed            sign-extend narrow loads when 1
//   stall, done, rdata   pipeline hold, completion pulse, aligned/extended load result
//   adel, ades           misaligned load / store flags (IDLE only)
//   data_*               SRAM-like handshake bus (req / addr_ok / data_ok)
module dmem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ADDR_W+2:0]        rreq,
    input  logic [ADDR_W+DATA_W+2:0] wreq,
    input  logic                     rd_signed,
    output logic                     stall,
    output logic [DATA_W-1:0]        rdata,
    output logic                     done,
    output logic                     adel,
    output logic                     ades,
    output logic                     data_req,
    output logic                     data_wr,
    output logic [1:0]               data_size,
    output logic [ADDR_W-1:0]        data_addr,
    output logic [DATA_W-1:0]        data_wdata,
    input  logic                     data_addr_ok,
    input  logic                     data_data_ok,
    input  logic [DATA_W-1:0]        data_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t              state, next_state;
    logic                wr_q, sgn_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;

    logic                r_valid, w_valid, sel_valid, misaligned, accept, capture;
    logic [ADDR_W-1:0]   sel_addr;
    logic [1:0]          sel_size;
    logic [DATA_W-1:0]   w_data, rep_data, shifted, load_data;

    assign r_valid   = rreq[ADDR_W+2];
    assign w_valid   = wreq[ADDR_W+DATA_W+2];
    assign w_data    = wreq[DATA_W+1:2];
    // A write wins when both are presented; the read is dropped.
    assign sel_valid = w_valid | r_valid;
    assign sel_addr  = w_valid ? wreq[ADDR_W+DATA_W+1:DATA_W+2] : rreq[ADDR_W+1:2];
    assign sel_size  = w_valid ? wreq[1:0] : rreq[1:0];
    // Size 3 behaves as word, so any size with bit 1 set needs word alignment.
    assign misaligned = (sel_size == 2'd1) ? sel_addr[0] : (sel_size[1] ? |sel_addr[1:0] : 1'b0);
    assign accept    = (state == IDLE) && sel_valid && !misaligned;
    assign adel      = (state == IDLE) && !w_valid && r_valid && misaligned;
    assign ades      = (state == IDLE) && w_valid && misaligned;

    assign rep_data  = (sel_size == 2'd0) ? {(DATA_W/8){w_data[7:0]}} :
                       (sel_size == 2'd1) ? {(DATA_W/16){w_data[15:0]}} : w_data;

    assign shifted   = data_rdata >> {addr_q[1:0], 3'b000};
    assign load_data = (size_q == 2'd0) ? {{(DATA_W-8){sgn_q & shifted[7]}}, shifted[7:0]} :
                       (size_q == 2'd1) ? {{(DATA_W-16){sgn_q & shifted[15]}}, shifted[15:0]} : shifted;

    // Read data is captured on data_ok, which may arrive together with addr_ok.
    assign capture   = data_data_ok && ((state == DATA) || (state == ADDR && data_addr_ok));

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? ADDR : IDLE;
            ADDR:    next_state = data_addr_ok ? (data_data_ok ? DONE : DATA) : ADDR;
            DATA:    next_state = data_data_ok ? DONE : DATA;
            default: next_state = IDLE;
        endcase
    end

    assign stall      = accept || state == ADDR || state == DATA;
    assign done       = state == DONE;
    assign data_req   = state == ADDR;
    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign rdata      = rdata_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            sgn_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                wr_q    <= w_valid;
                sgn_q   <= rd_signed;
                size_q  <= sel_size;
                addr_q  <= sel_addr;
                wdata_q <= rep_data;
            end
            if (capture) rdata_q <= wr_q ? '0 : load_data;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder.
module tb_dmem_responder;
    logic        clk = 0;
    logic        resetn = 0;
    logic [34:0] rreq = '0;
    logic [66:0] wreq = '0;
    logic        rd_signed = 0;
    logic        stall, done, adel, ades, data_req, data_wr;
    logic [31:0] rdata, data_addr, data_wdata;
    logic [1:0]  data_size;
    logic        data_addr_ok = 0, data_data_ok = 0;
    logic [31:0] data_rdata = '0;
    int          pass_cnt = 0, total = 0;

    dmem_responder dut (
        .clk(clk), .resetn(resetn), .rreq(rreq), .wreq(wreq), .rd_signed(rd_signed),
        .stall(stall), .rdata(rdata), .done(done), .adel(adel), .ades(ades),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] mk_r(input logic [31:0] a, input logic [1:0] s);
        return {1'b1, a, s};
    endfunction

    function automatic logic [66:0] mk_w(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        return {1'b1, a, d, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request with addr_ok and data_ok both in the first ADDR cycle,
    // returning done/rdata observed in the cycle after that.
    task automatic run_fast(input logic [34:0] r, input logic [66:0] w, input logic sg,
                            input logic [31:0] bus, output logic got_done, output logic [31:0] got);
        rreq = r; wreq = w; rd_signed = sg;
        step();
        rreq = '0; wreq = '0; rd_signed = 0;
        data_addr_ok = 1; data_data_ok = 1; data_rdata = bus;
        step();
        data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
        #1;
        got_done = done; got = rdata;
        step();
    endtask

    task automatic test_reset();
        resetn = 0;
        step(); step();
        #1;
        total++;
        if ({stall, done, data_req, data_wr} !== 4'b0) $display("FAIL reset_ctl got %b want 0000", {stall, done, data_req, data_wr});
        else pass_cnt++;
        total++;
        if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 00000000", rdata);
        else pass_cnt++;
        total++;
        if ({data_size, data_addr, data_wdata} !== 66'h0) $display("FAIL reset_bus got %h %h %h want 0", data_size, data_addr, data_wdata);
        else pass_cnt++;
        resetn = 1;
        step();
    endtask

    task automatic test_lw();
        rreq = mk_r(32'h10, 2'd2);
        #1;
        total++;
        if ({stall, data_req} !== 2'b10) $display("FAIL lw_c0 stall/req got %b want 10", {stall, data_req});
        else pass_cnt++;
        step();
        rreq = '0; data_addr_ok = 1;
        #1;
        total++;
        if ({stall, data_req, data_wr, data_size, data_addr} !== {3'b110, 2'd2, 32'h10})
            $display("FAIL lw_c1 got %b%b%b %0d %h want 110 2 00000010", stall, data_req, data_wr, data_size, data_addr);
        else pass_cnt++;
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEADBEEF;
        #1;
        total++;
        if ({stall, data_req, done} !== 3'b100) $display("FAIL lw_c2 stall/req/done got %b want 100", {stall, data_req, done});
        else pass_cnt++;
        step();
        data_data_ok = 0; data_rdata = '0;
        #1;
        total++;
        if ({stall, done, rdata} !== {2'b01, 32'hDEADBEEF}) $display("FAIL lw_c3 got stall=%b done=%b rdata=%h want 0 1 deadbeef", stall, done, rdata);
        else pass_cnt++;
        step();
        total++;
        if (done !== 1'b0) $display("FAIL lw_pulse done got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_load_ext();
        logic        d;
        logic [31:0] r;
        run_fast(mk_r(32'h13, 2'd0), '0, 1'b1, 32'h80112233, d, r);
        total++;
        if ({d, r} !== {1'b1, 32'hFFFFFF80}) $display("FAIL lb_signed got done=%b rdata=%h want 1 ffffff80", d, r);
        else pass_cnt++;
        run_fast(mk_r(32'h13, 2'd0), '0, 1'b0, 32'h80112233, d, r);
        total++;
        if ({d, r} !== {1'b1, 32'h00000080}) $display("FAIL lb_unsigned got done=%b rdata=%h want 1 00000080", d, r);
        else pass_cnt++;
        run_fast(mk_r(32'h22, 2'd1), '0, 1'b1, 32'h80010000, d, r);
        total++;
        if ({d, r} !== {1'b1, 32'hFFFF8001}) $display("FAIL lh_signed got done=%b rdata=%h want 1 ffff8001", d, r);
        else pass_cnt++;
        run_fast(mk_r(32'h21, 2'd0), '0, 1'b1, 32'h80117F33, d, r);
        total++;
        if ({d, r} !== {1'b1, 32'h0000007F}) $display("FAIL lb_pos got done=%b rdata=%h want 1 0000007f", d, r);
        else pass_cnt++;
    endtask

    task automatic test_store_half();
        wreq = mk_w(32'h102, 32'h1234ABCD, 2'd1);
        step();
        wreq = '0;
        #1;
        total++;
        if ({data_req, data_wr, data_size, data_addr, data_wdata} !== {2'b11, 2'd1, 32'h102, 32'hABCDABCD})
            $display("FAIL sh_bus got %b%b %0d %h %h want 11 1 00000102 abcdabcd", data_req, data_wr, data_size, data_addr, data_wdata);
        else pass_cnt++;
        data_addr_ok = 1;
        step();
        data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h55555555;
        step();
        data_data_ok = 0; data_rdata = '0;
        #1;
        total++;
        if ({done, rdata} !== {1'b1, 32'h0}) $display("FAIL sh_done got done=%b rdata=%h want 1 00000000", done, rdata);
        else pass_cnt++;
        step();
    endtask

    task automatic test_store_byte();
        logic        d;
        logic [31:0] r;
        wreq = mk_w(32'h43, 32'h000000A5, 2'd0);
        #1;
        step();
        wreq = '0;
        #1;
        total++;
        if ({data_wr, data_size, data_wdata} !== {1'b1, 2'd0, 32'hA5A5A5A5}) $display("FAIL sb_bus got %b %0d %h want 1 0 a5a5a5a5", data_wr, data_size, data_wdata);
        else pass_cnt++;
        data_addr_ok = 1; data_data_ok = 1;
        step();
        data_addr_ok = 0; data_data_ok = 0;
        #1;
        d = done; r = rdata;
        total++;
        if ({d, r} !== {1'b1, 32'h0}) $display("FAIL sb_done got done=%b rdata=%h want 1 00000000", d, r);
        else pass_cnt++;
        step();
    endtask

    task automatic test_misaligned();
        rreq = mk_r(32'h6, 2'd2);
        #1;
        total++;
        if ({adel, ades, stall, data_req} !== 4'b1000) $display("FAIL lw_mis got adel/ades/stall/req=%b want 1000", {adel, ades, stall, data_req});
        else pass_cnt++;
        step();
        #1;
        total++;
        if ({adel, data_req, stall} !== 3'b100) $display("FAIL lw_mis_hold got adel/req/stall=%b want 100", {adel, data_req, stall});
        else pass_cnt++;
        rreq = '0; wreq = mk_w(32'h1, 32'h11223344, 2'd2);
        #1;
        total++;
        if ({adel, ades, stall, data_req} !== 4'b0100) $display("FAIL sw_mis got adel/ades/stall/req=%b want 0100", {adel, ades, stall, data_req});
        else pass_cnt++;
        wreq = mk_w(32'h3, 32'h11223344, 2'd1);
        #1;
        total++;
        if ({ades, stall} !== 2'b10) $display("FAIL sh_mis got ades/stall=%b want 10", {ades, stall});
        else pass_cnt++;
        step();
        wreq = '0;
        #1;
        total++;
        if ({data_req, stall, ades} !== 3'b000) $display("FAIL mis_nobus got req/stall/ades=%b want 000", {data_req, stall, ades});
        else pass_cnt++;
    endtask

    task automatic test_addr_wait();
        wreq = mk_w(32'h200, 32'hCAFEF00D, 2'd2);
        rreq = mk_r(32'h300, 2'd2);
        #1;
        total++;
        if ({stall, adel, ades} !== 3'b100) $display("FAIL both_c0 got stall/adel/ades=%b want 100", {stall, adel, ades});
        else pass_cnt++;
        step();
        wreq = '0; rreq = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if ({data_req, data_wr, stall, data_addr, data_wdata} !== {3'b111, 32'h200, 32'hCAFEF00D})
                $display("FAIL wait_hold%0d got %b%b%b %h %h want 111 00000200 cafef00d", i, data_req, data_wr, stall, data_addr, data_wdata);
            else pass_cnt++;
            step();
        end
        data_addr_ok = 1;
        step();
        data_addr_ok = 0;
        #1;
        total++;
        if ({data_req, stall} !== 2'b01) $display("FAIL wait_data got req/stall=%b want 01", {data_req, stall});
        else pass_cnt++;
        data_data_ok = 1;
        step();
        data_data_ok = 0;
        #1;
        total++;
        if (done !== 1'b1) $display("FAIL wait_done got %b want 1", done);
        else pass_cnt++;
        step(); step();
        total++;
        if ({data_req, stall, done} !== 3'b000) $display("FAIL wait_single got req/stall/done=%b want 000", {data_req, stall, done});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rreq = mk_r(32'h40, 2'd2);
        step();
        rreq = '0; data_addr_ok = 1;
        step();
        data_addr_ok = 0;
        resetn = 0;
        step();
        resetn = 1;
        #1;
        total++;
        if ({stall, done, data_req, data_addr} !== {3'b000, 32'h0}) $display("FAIL rst_mid got stall/done/req=%b addr=%h want 000 0", {stall, done, data_req}, data_addr);
        else pass_cnt++;
        data_data_ok = 1; data_rdata = 32'h12345678;
        step();
        data_data_ok = 0;
        #1;
        total++;
        if ({stall, done, rdata} !== {2'b00, 32'h0}) $display("FAIL rst_late_ok got stall=%b done=%b rdata=%h want 0 0 0", stall, done, rdata);
        else pass_cnt++;
        step();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store_half();
        test_store_byte();
        test_misaligned();
        test_addr_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
